// File: rtl/sdr_frame_arbiter.sv
// SDRAM app-port arbiter: fixed-length write/read bursts, round-robin fairness,
// triple-buffered frame banks so readout never sees a torn frame.
module sdr_frame_arbiter #(
  parameter int ADDR_WIDTH  = 21,
  parameter int FRAME_WORDS = 307200,
  parameter int BURST_LEN   = 4,
  parameter int BANK_STRIDE = 524288,
  parameter int RD_LIMIT    = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            wr_level,
  input  logic [11:0]           rd_fifo_used,
  input  logic                  sdr_busy,
  input  logic                  sdr_ref_vld,
  output logic                  app_wr_en,
  output logic [ADDR_WIDTH-1:0] app_wr_addr,
  output logic                  app_rd_en,
  output logic [ADDR_WIDTH-1:0] app_rd_addr,
  output logic [1:0]            wr_bank,
  output logic [1:0]            rd_bank,
  output logic                  frame_valid,
  output logic                  wr_frame_done,
  output logic                  rd_frame_done
);

  localparam int OW = 19;
  localparam int CW = $clog2(BURST_LEN + 1);

  localparam logic [OW-1:0] LAST_OFS = OW'(FRAME_WORDS - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [9:0] WR_MIN = 10'(BURST_LEN);
  localparam logic [11:0] RD_MAX = 12'(RD_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(BANK_STRIDE);

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST,
    GAP
  } state_t;

  state_t state, next_state;

  logic [CW-1:0] cnt;
  logic          last_rd;
  logic [1:0]    latest;
  logic [OW-1:0] wr_ofs;
  logic [OW-1:0] rd_ofs;
  logic          wr_last;
  logic          rd_last;
  logic          wr_elig;
  logic          rd_elig;
  logic          grant_wr;
  logic          grant_rd;
  logic          burst_end;
  logic [1:0]    rd_bank_nxt;
  logic [1:0]    wr_bank_nxt;

  function automatic logic [ADDR_WIDTH-1:0] addr_of(
    input logic [1:0]    b,
    input logic [OW-1:0] o
  );
    return ADDR_WIDTH'(b) * STRIDE + ADDR_WIDTH'(o);
  endfunction

  always_comb begin
    wr_elig = !sdr_busy && !sdr_ref_vld
              && (wr_level >= WR_MIN);
    rd_elig = !sdr_busy && !sdr_ref_vld
              && frame_valid
              && (rd_fifo_used < RD_MAX);
    // on a tie the channel that did not win last time goes
    grant_wr = wr_elig && !(rd_elig && !last_rd);
    grant_rd = rd_elig && !grant_wr;
    burst_end = (cnt == LAST_BEAT);

    next_state = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grant_wr: next_state = WR_BURST;
          grant_rd: next_state = RD_BURST;
          default:  next_state = IDLE;
        endcase
      end
      WR_BURST: if (burst_end) next_state = GAP;
      RD_BURST: if (burst_end) next_state = GAP;
      GAP:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase

    rd_bank_nxt = rd_bank;
    if (state == IDLE && rd_ofs == '0)
      rd_bank_nxt = latest;

    // lowest bank that is neither the one just filled nor the one being read
    if (wr_bank != 2'd0 && rd_bank != 2'd0)
      wr_bank_nxt = 2'd0;
    else if (wr_bank != 2'd1 && rd_bank != 2'd1)
      wr_bank_nxt = 2'd1;
    else
      wr_bank_nxt = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      last_rd <= 1'b1;
    end else begin
      state <= next_state;
      if (state == WR_BURST || state == RD_BURST)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      if (next_state == WR_BURST && state == IDLE)
        last_rd <= 1'b0;
      else if (next_state == RD_BURST && state == IDLE)
        last_rd <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      app_wr_en     <= 1'b0;
      app_rd_en     <= 1'b0;
      app_wr_addr   <= '0;
      app_rd_addr   <= '0;
      wr_ofs        <= '0;
      rd_ofs        <= '0;
      wr_last       <= 1'b0;
      rd_last       <= 1'b0;
      wr_bank       <= 2'd0;
      rd_bank       <= 2'd2;
      latest        <= 2'd0;
      frame_valid   <= 1'b0;
      wr_frame_done <= 1'b0;
      rd_frame_done <= 1'b0;
    end else begin
      app_wr_en     <= (next_state == WR_BURST);
      app_rd_en     <= (next_state == RD_BURST);
      wr_last       <= 1'b0;
      rd_last       <= 1'b0;
      wr_frame_done <= wr_last;
      rd_frame_done <= rd_last;

      if (next_state == WR_BURST) begin
        app_wr_addr <= addr_of(wr_bank, wr_ofs);
        wr_ofs      <= (wr_ofs == LAST_OFS) ? '0 : wr_ofs + OW'(1);
        wr_last     <= (wr_ofs == LAST_OFS);
      end

      if (next_state == RD_BURST) begin
        rd_bank     <= rd_bank_nxt;
        app_rd_addr <= addr_of(rd_bank_nxt, rd_ofs);
        rd_ofs      <= (rd_ofs == LAST_OFS) ? '0 : rd_ofs + OW'(1);
        rd_last     <= (rd_ofs == LAST_OFS);
      end

      // frame handover lands one cycle after the last strobe
      if (wr_last) begin
        latest      <= wr_bank;
        frame_valid <= 1'b1;
        wr_bank     <= wr_bank_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sdr_frame_arbiter.sv
// Bench for sdr_frame_arbiter: per-cycle strobe table plus an address and
// burst-order scoreboard fed by hand-written frame/bank sequences.
module tb_sdr_frame_arbiter;

  localparam int AW = 21;
  localparam int FW = 16;
  localparam int BL = 4;
  localparam int BS = 524288;
  localparam int RL = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    wr_level = '0;
  logic [11:0]   rd_fifo_used = '0;
  logic          sdr_busy = 1'b0;
  logic          sdr_ref_vld = 1'b0;
  logic          app_wr_en;
  logic [AW-1:0] app_wr_addr;
  logic          app_rd_en;
  logic [AW-1:0] app_rd_addr;
  logic [1:0]    wr_bank;
  logic [1:0]    rd_bank;
  logic          frame_valid;
  logic          wr_frame_done;
  logic          rd_frame_done;

  sdr_frame_arbiter #(
    .ADDR_WIDTH (AW),
    .FRAME_WORDS(FW),
    .BURST_LEN  (BL),
    .BANK_STRIDE(BS),
    .RD_LIMIT   (RL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_level     (wr_level),
    .rd_fifo_used (rd_fifo_used),
    .sdr_busy     (sdr_busy),
    .sdr_ref_vld  (sdr_ref_vld),
    .app_wr_en    (app_wr_en),
    .app_wr_addr  (app_wr_addr),
    .app_rd_en    (app_rd_en),
    .app_rd_addr  (app_rd_addr),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank),
    .frame_valid  (frame_valid),
    .wr_frame_done(wr_frame_done),
    .rd_frame_done(rd_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  wl;
    logic [11:0] ru;
    logic        busy;
    logic        refv;
    logic        ewr;
    logic        erd;
  } vec_t;

  vec_t vecs[$];
  int   exp_wr[$];
  int   exp_rd[$];
  int   exp_kind[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int wl, input int ru, input bit b,
                         input bit r, input bit ew, input bit er,
                         input int n);
    vec_t v;
    v.wl = 10'(wl);
    v.ru = 12'(ru);
    v.busy = b;
    v.refv = r;
    v.ewr = ew;
    v.erd = er;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic push_wr(input int a);
    exp_kind.push_back(0);
    for (int i = 0; i < BL; i++) exp_wr.push_back(a + i);
  endtask

  task automatic push_rd(input int a);
    exp_kind.push_back(1);
    for (int i = 0; i < BL; i++) exp_rd.push_back(a + i);
  endtask

  task automatic step(input int wl, input int ru, input bit b, input bit r);
    @(negedge clk);
    wr_level = 10'(wl);
    rd_fifo_used = 12'(ru);
    sdr_busy = b;
    sdr_ref_vld = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, RL, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (app_wr_en && !prev_wr) begin
        if (exp_kind.size() == 0) begin
          tests++; fails++;
          $display("FAIL burst_order: got write expected none");
        end else chk("burst_order", 0, exp_kind.pop_front());
      end
      if (app_rd_en && !prev_rd) begin
        if (exp_kind.size() == 0) begin
          tests++; fails++;
          $display("FAIL burst_order: got read expected none");
        end else chk("burst_order", 1, exp_kind.pop_front());
      end
      if (app_wr_en) begin
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL wr_addr: got %0d expected no strobe", app_wr_addr);
        end else chk("wr_addr", 32'(app_wr_addr), exp_wr.pop_front());
      end
      if (app_rd_en) begin
        if (exp_rd.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_addr: got %0d expected no strobe", app_rd_addr);
        end else chk("rd_addr", 32'(app_rd_addr), exp_rd.pop_front());
      end
      if (app_wr_en || app_rd_en)
        chk("exclusive", 32'(app_wr_en & app_rd_en), 0);
    end
    prev_wr = app_wr_en;
    prev_rd = app_rd_en;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(app_wr_en), 0);
    chk("rst_rd_en", 32'(app_rd_en), 0);
    chk("rst_wr_addr", 32'(app_wr_addr), 0);
    chk("rst_rd_addr", 32'(app_rd_addr), 0);
    chk("rst_wr_bank", 32'(wr_bank), 0);
    chk("rst_rd_bank", 32'(rd_bank), 2);
    chk("rst_frame_valid", 32'(frame_valid), 0);
    chk("rst_wr_done", 32'(wr_frame_done), 0);
    chk("rst_rd_done", 32'(rd_frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // write-only cadence, refresh hold, busy hold, refresh mid-burst
    push_wr(0);
    push_wr(4);
    push_wr(8);
    add_vec(8, 0, 0, 0, 1, 0, 4);
    add_vec(8, 0, 0, 0, 0, 0, 2);
    add_vec(8, 0, 0, 0, 1, 0, 4);
    add_vec(8, 0, 0, 0, 0, 0, 2);
    add_vec(100, 0, 0, 1, 0, 0, 20);
    add_vec(100, 0, 1, 0, 0, 0, 3);
    add_vec(100, 0, 0, 0, 1, 0, 1);
    add_vec(100, 0, 0, 1, 1, 0, 3);
    add_vec(100, 0, 0, 1, 0, 0, 4);
    add_vec(0, 0, 0, 0, 0, 0, 2);
    foreach (vecs[i]) begin
      step(vecs[i].wl, vecs[i].ru, vecs[i].busy, vecs[i].refv);
      chk($sformatf("tbl_wr_en[%0d]", i), 32'(app_wr_en), 32'(vecs[i].ewr));
      chk($sformatf("tbl_rd_en[%0d]", i), 32'(app_rd_en), 32'(vecs[i].erd));
    end

    // frame rollover into bank 1
    push_wr(12);
    step(8, RL, 0, 0);
    chk("roll_wr_en", 32'(app_wr_en), 1);
    idle(3);
    chk("roll_last_addr", 32'(app_wr_addr), FW - 1);
    chk("roll_done_early", 32'(wr_frame_done), 0);
    idle(1);
    chk("roll_done", 32'(wr_frame_done), 1);
    chk("roll_valid", 32'(frame_valid), 1);
    chk("roll_wr_bank", 32'(wr_bank), 1);
    idle(1);
    chk("roll_done_pulse", 32'(wr_frame_done), 0);

    // first read frame starts at base(latest = 0)
    push_rd(0);
    step(0, 0, 0, 0);
    chk("rd_first_en", 32'(app_rd_en), 1);
    idle(5);
    chk("rd_first_bank", 32'(rd_bank), 0);

    // tie: last grant was read, so write first, then alternate
    push_wr(BS);
    push_rd(4);
    push_wr(BS + 4);
    push_rd(8);
    repeat (24) step(8, 0, 0, 0);
    chk("tie_rd_bank", 32'(rd_bank), 0);
    chk("tie_wr_bank", 32'(wr_bank), 1);

    // backpressure while writer finishes bank 1; reader still on bank 0
    push_wr(BS + 8);
    push_wr(BS + 12);
    repeat (12) step(8, RL, 0, 0);
    chk("tri_wr_bank", 32'(wr_bank), 2);
    chk("tri_valid", 32'(frame_valid), 1);

    push_rd(12);
    step(0, RL - 1, 0, 0);
    chk("bp_release_en", 32'(app_rd_en), 1);
    idle(3);
    chk("rd_done_early", 32'(rd_frame_done), 0);
    idle(1);
    chk("rd_done", 32'(rd_frame_done), 1);
    idle(1);

    push_rd(BS);
    step(0, RL - 1, 0, 0);
    chk("rd_next_en", 32'(app_rd_en), 1);
    chk("rd_next_bank", 32'(rd_bank), 1);
    idle(7);

    chk("sb_wr_left", 32'(exp_wr.size()), 0);
    chk("sb_rd_left", 32'(exp_rd.size()), 0);
    chk("sb_kind_left", 32'(exp_kind.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
